// File: rtl/cache_stats_unit.sv
// Cache event counters with snapshot and hit-ratio divider (one quotient bit per cycle).
// snap_ack after 1 cycle (no hits/misses) or FRAC+2 cycles; snap_req is dropped while busy.
module cache_stats_unit #(
  parameter int CNT_WIDTH = 32,
  parameter int FRAC      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ev_valid,
  input  logic                 ev_hit,
  input  logic                 ev_miss,
  input  logic                 ev_read,
  input  logic                 ev_write,
  input  logic                 clear,
  input  logic                 snap_req,
  output logic                 snap_ack,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] read_cnt,
  output logic [CNT_WIDTH-1:0] write_cnt,
  output logic [FRAC:0]        ratio,
  output logic [3:0]           sat,
  output logic                 err
);

  localparam int STEP_W = $clog2(FRAC + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAC);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIVIDE = 2'd1, S_DONE = 2'd2} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [3:0][CNT_WIDTH-1:0]      r_live;
  logic [3:0]                     w_inc;
  logic [CNT_WIDTH:0]             w_den;
  logic [CNT_WIDTH:0]             r_den;
  logic [CNT_WIDTH+1:0]           r_rem;
  logic [CNT_WIDTH:0]             w_rem_sub;
  logic                           w_ge;
  logic [FRAC-1:0]                r_quo;
  logic [STEP_W-1:0]              r_step;
  logic                           w_last;

  // Simultaneous hit and miss is a protocol error: neither is counted.
  assign w_inc[0] = ev_valid & ev_hit & ~ev_miss;
  assign w_inc[1] = ev_valid & ev_miss & ~ev_hit;
  assign w_inc[2] = ev_valid & ev_read;
  assign w_inc[3] = ev_valid & ev_write;

  assign w_den     = {1'b0, r_live[0]} + {1'b0, r_live[1]};
  assign w_last    = (r_step == LAST_STEP);
  assign w_ge      = (r_rem >= {1'b0, r_den});
  assign w_rem_sub = w_ge ? (CNT_WIDTH+1)'(r_rem - {1'b0, r_den}) : r_rem[CNT_WIDTH:0];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_live <= '0;
      sat    <= '0;
      err    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_inc[i]) begin
          if (&r_live[i]) sat[i] <= 1'b1;
          else            r_live[i] <= r_live[i] + CNT_WIDTH'(1);
        end
      end
      if (ev_valid && ev_hit && ev_miss) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (snap_req) w_state_nxt = (w_den == '0) ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (w_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    snap_ack = (r_state == S_DONE);
  end

  // Remainder starts at hit count; since hit <= D the first quotient bit carries weight 2^FRAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      read_cnt  <= '0;
      write_cnt <= '0;
      ratio     <= '0;
      r_den     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_step    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            hit_cnt   <= r_live[0];
            miss_cnt  <= r_live[1];
            read_cnt  <= r_live[2];
            write_cnt <= r_live[3];
            r_den     <= w_den;
            r_rem     <= {1'b0, {1'b0, r_live[0]}};
            r_quo     <= '0;
            r_step    <= '0;
            if (w_den == '0) ratio <= '0;
          end
        end
        S_DIVIDE: begin
          r_quo  <= FRAC'({r_quo, w_ge});
          r_rem  <= {w_rem_sub, 1'b0};
          r_step <= r_step + STEP_W'(1);
          if (w_last) ratio <= {r_quo, w_ge};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_stats_unit.md
CACHE_STATS_UNIT -- requirements
Module: cache_stats_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of each event counter and each snapshot count.
REQ-002 Parameter FRAC, default 8: fractional bits of the hit-ratio result.
REQ-003 Design SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ev_valid  in  1  qualifies ev_* flags this cycle.
REQ-007 ev_hit, ev_miss, ev_read, ev_write  in  1 each  event flags.
REQ-008 clear  in  1  zeroes live counters and sticky flags.
REQ-009 snap_req  in  1  request snapshot plus ratio computation.
REQ-010 snap_ack  out  1  one-cycle pulse: snapshot and ratio valid.
REQ-011 busy  out  1  snapshot in progress.
REQ-012 hit_cnt, miss_cnt, read_cnt, write_cnt  out  CNT_WIDTH each  snapshot counts.
REQ-013 ratio  out  FRAC+1  floor(hit*2^FRAC/(hit+miss)), unsigned Q1.FRAC.
REQ-014 sat  out  4  sticky saturation flags, bit order {write,read,miss,hit}.
REQ-015 err  out  1  sticky flag: ev_hit and ev_miss set together.

Function
REQ-016 Live counters (internal) SHALL increment by 1 on each edge with ev_valid=1 and their flag=1; ev_* SHALL be ignored when ev_valid=0.
REQ-017 ev_read/ev_write SHALL count independently of each other and of hit/miss.
REQ-018 ev_hit=ev_miss=1 with ev_valid: neither hit nor miss counts; err set; read/write still count.
REQ-019 Counter at all-ones SHALL hold (saturate) and set its sat bit on the attempted increment.
REQ-020 clear SHALL zero all live counters, sat and err at the next edge; clear wins over same-cycle events.
REQ-021 clear SHALL NOT affect snapshot outputs, ratio or an in-progress computation.
REQ-022 FSM states IDLE, DIVIDE, DONE; busy=1 in DIVIDE and DONE.
REQ-023 IDLE with snap_req=1 (cycle 0): copy live counter values as registered before cycle-0 events into snapshot outputs; same-cycle events go to live counters only.
REQ-024 Denominator D = hit_cnt+miss_cnt computed at CNT_WIDTH+1 bits (no overflow).
REQ-025 D=0: IDLE -> DONE directly, ratio=0, snap_ack at cycle 1.
REQ-026 D>0: IDLE -> DIVIDE; restoring division one quotient bit per cycle, MSB first, FRAC+1 cycles (cycles 1..FRAC+1); then DONE, snap_ack at cycle FRAC+2.
REQ-027 ratio SHALL update on DONE entry and hold until the next DONE entry; maximum value 2^FRAC.
REQ-028 DONE -> IDLE after one cycle unconditionally; snap_ack high only in DONE.
REQ-029 snap_req while busy=1 SHALL be ignored (not queued); snap_req in the DONE cycle is ignored.
REQ-030 Live counting SHALL continue unaffected during DIVIDE/DONE.

Reset
REQ-031 reset SHALL force IDLE; zero live counters, snapshot outputs and ratio; clear sat and err; drive snap_ack=0 and busy=0.
REQ-032 reset mid-DIVIDE SHALL abort with no snap_ack; reset overrides clear, events and snap_req.

Verification
REQ-033 FRAC=8: 3 hits and 1 miss, then snap_req -> ack at cycle 10; hit_cnt=3, miss_cnt=1, ratio=192.
REQ-034 No events, snap_req -> ack at cycle 1; ratio=0; all counts 0.
REQ-035 5 hits, 0 misses, 2 reads, 4 writes, snap -> ratio=256, read_cnt=2, write_cnt=4.
REQ-036 CNT_WIDTH=4: 20 hits, snap -> hit_cnt=15, sat=4'b0001; clear then snap -> hit_cnt=0, sat=0.
REQ-037 ev_valid with ev_hit=ev_miss=ev_read=1 -> err=1; snapshot shows hit=0, miss=0, read=1.
REQ-038 snap_req then reset at cycle 4 -> no snap_ack; busy=0, ratio=0 next cycle; second snap_req during DIVIDE yields exactly one ack.
